comm_frame_done_gen: RTL and testbench

Frame-completion generator for the host communication link: tracks one transfer frame from its start request, counts transferred words, and emits a single-cycle finish pulse when the frame's last word has moved. Its `oFINISH` is the source flag for the downstream 10-stage communication-done delay chain, and it shares that chain's clock enable. A word-gap timeout aborts stalled frames so the link never hangs busy.

---
 rtl/comm_pkg.sv | 17 +
 rtl/comm_gap_timer.sv | 47 ++++
 rtl/comm_frame_done_gen.sv | 129 ++++++++++++
 tb/tb_comm_frame_done_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the host communication link: frame FSM states and
// default frame/timeout dimensions. Also used by the done delay chain.
package comm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } comm_state_t;

  localparam int unsigned FRAME_LEN_DEF = 256;
  localparam int unsigned CNT_WL_DEF    = 9;
  localparam int unsigned TIMEOUT_DEF   = 1023;
  localparam int unsigned TO_WL_DEF     = 10;

endpackage : comm_pkg

// File: rtl/comm_gap_timer.sv
// Word-gap timer: enabled, clearable up-counter that saturates at TIMEOUT-1
// and flags that terminal value so the frame FSM can abort a stalled frame.
module comm_gap_timer
  import comm_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TO_WL   = TO_WL_DEF
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic iCLR,   // synchronous clear, acts even when iEN=0
  input  logic iEN,    // clock enable
  input  logic iZERO,  // restart the gap (word seen or not in RUN)
  input  logic iINC,   // one more idle cycle in RUN
  output logic oTERM   // counter sits at TIMEOUT-1
);

  localparam logic [TO_WL-1:0] TERM_VAL = TO_WL'(TIMEOUT - 1);

  logic [TO_WL-1:0] cnt_d, cnt_q;

  // Next gap count: clear wins, then restart, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (iCLR) begin
      cnt_d = '0;
    end else if (iEN) begin
      if (iZERO) begin
        cnt_d = '0;
      end else if (iINC && (cnt_q != TERM_VAL)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Gap count register.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oTERM = (cnt_q == TERM_VAL);

endmodule : comm_gap_timer

// File: rtl/comm_frame_done_gen.sv
// Frame-completion generator: tracks one transfer frame, counts words and
// emits a one-enabled-cycle finish pulse (or a timeout pulse on a stalled
// frame). oFINISH feeds the done delay chain, which shares iEN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame; waiting for iSTART
// ST_RUN   | frame in progress; counting words and idle gap
// ST_DONE  | last word moved; oFINISH high for one enabled cycle
// ST_ABORT | gap timer expired; oTIMEOUT high for one enabled cycle
module comm_frame_done_gen
  import comm_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned CNT_WL    = CNT_WL_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned TO_WL     = TO_WL_DEF
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iCLR,
  input  logic              iEN,
  input  logic              iSTART,
  input  logic              iVALID,
  output logic              oBUSY,
  output logic [CNT_WL-1:0] oWORD_CNT,
  output logic              oFINISH,
  output logic              oTIMEOUT
);

  localparam logic [CNT_WL-1:0] LAST_IDX = CNT_WL'(FRAME_LEN - 1);
  localparam logic [CNT_WL-1:0] FULL_CNT = CNT_WL'(FRAME_LEN);

  comm_state_t       state_d, state_q;
  logic [CNT_WL-1:0] word_cnt_d, word_cnt_q;
  logic              busy_d, busy_q;
  logic              finish_d, finish_q;
  logic              timeout_d, timeout_q;

  logic              in_run;
  logic              gap_term;

  assign in_run = (state_q == ST_RUN);

  // Gap timer restarts on every word and whenever the frame is not running,
  // so each RUN entry begins with a zero gap count.
  comm_gap_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_WL   (TO_WL)
  ) u_gap_timer (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iCLR  (iCLR),
    .iEN   (iEN),
    .iZERO (!in_run || iVALID),
    .iINC  (in_run && !iVALID),
    .oTERM (gap_term)
  );

  // Next state and word count; outputs are decoded from the next state so
  // they come straight out of flops.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    if (iCLR) begin
      state_d    = ST_IDLE;
      word_cnt_d = '0;
    end else if (iEN) begin
      unique case (state_q)
        ST_IDLE: begin
          if (iSTART) begin
            state_d    = ST_RUN;
            word_cnt_d = '0;
          end
        end
        ST_RUN: begin
          if (iVALID) begin
            if (word_cnt_q != FULL_CNT) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
            if (word_cnt_q == LAST_IDX) begin
              state_d = ST_DONE;
            end
          end else if (gap_term) begin
            state_d = ST_ABORT;
          end
        end
        ST_DONE, ST_ABORT: begin
          if (iSTART) begin
            state_d    = ST_RUN;
            word_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
        end
      endcase
    end
    busy_d    = (state_d == ST_RUN);
    finish_d  = (state_d == ST_DONE);
    timeout_d = (state_d == ST_ABORT);
  end

  // State, word counter and registered status outputs.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      timeout_q  <= timeout_d;
    end
  end

  assign oBUSY     = busy_q;
  assign oWORD_CNT = word_cnt_q;
  assign oFINISH   = finish_q;
  assign oTIMEOUT  = timeout_q;

endmodule : comm_frame_done_gen

// File: tb/tb_comm_frame_done_gen.sv
// Directed bench: main instance with FRAME_LEN=4/TIMEOUT=8, a second with
// FRAME_LEN=1 sharing the same inputs for the single-word frame boundary.
module tb_comm_frame_done_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, en, start, valid;
  logic       busy, finish, tmo;
  logic [8:0] wcnt;
  logic       busy1, finish1, tmo1;
  logic [8:0] wcnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  comm_frame_done_gen #(.FRAME_LEN(4), .CNT_WL(9), .TIMEOUT(8), .TO_WL(10)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr), .iEN(en), .iSTART(start), .iVALID(valid),
    .oBUSY(busy), .oWORD_CNT(wcnt), .oFINISH(finish), .oTIMEOUT(tmo)
  );

  comm_frame_done_gen #(.FRAME_LEN(1), .CNT_WL(9), .TIMEOUT(8), .TO_WL(10)) dut1 (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr), .iEN(en), .iSTART(start), .iVALID(valid),
    .oBUSY(busy1), .oWORD_CNT(wcnt1), .oFINISH(finish1), .oTIMEOUT(tmo1)
  );

  // Advance one clock and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 0; en = 1; start = 0; valid = 0;
    step(); step();
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b000, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got b=%0b f=%0b t=%0b cnt=%0d, want all 0", busy, finish, tmo, wcnt);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b000, 9'd0}) begin
      n_fail++;
      $display("FAIL idle_after_reset: got b=%0b f=%0b t=%0b cnt=%0d, want all 0", busy, finish, tmo, wcnt);
    end
  endtask

  task automatic test_nominal();
    start = 1; step(); start = 0;
    n_checks++;
    if ({busy, finish, wcnt} !== {2'b10, 9'd0}) begin
      n_fail++;
      $display("FAIL nom_start: got b=%0b f=%0b cnt=%0d, want b=1 f=0 cnt=0", busy, finish, wcnt);
    end
    valid = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if ({busy, finish, tmo, wcnt} !== {3'b100, 9'(i)}) begin
        n_fail++;
        $display("FAIL nom_word%0d: got b=%0b f=%0b t=%0b cnt=%0d, want b=1 f=0 t=0 cnt=%0d", i, busy, finish, tmo, wcnt, i);
      end
    end
    step(); valid = 0;
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b010, 9'd4}) begin
      n_fail++;
      $display("FAIL nom_finish: got b=%0b f=%0b t=%0b cnt=%0d, want b=0 f=1 t=0 cnt=4", busy, finish, tmo, wcnt);
    end
    step();
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b000, 9'd4}) begin
      n_fail++;
      $display("FAIL nom_after: got b=%0b f=%0b t=%0b cnt=%0d, want b=0 f=0 t=0 cnt=4", busy, finish, tmo, wcnt);
    end
  endtask

  task automatic test_timeout();
    int seen_fin = 0;
    start = 1; step(); start = 0;
    valid = 1; step(); step(); valid = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (finish) seen_fin++;
      n_checks++;
      if ({busy, tmo} !== 2'b10) begin
        n_fail++;
        $display("FAIL to_wait%0d: got b=%0b t=%0b, want b=1 t=0", i, busy, tmo);
      end
    end
    step();
    if (finish) seen_fin++;
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b001, 9'd2}) begin
      n_fail++;
      $display("FAIL to_pulse: got b=%0b f=%0b t=%0b cnt=%0d, want b=0 f=0 t=1 cnt=2", busy, finish, tmo, wcnt);
    end
    step();
    if (finish) seen_fin++;
    n_checks++;
    if ({busy, tmo, wcnt} !== {2'b00, 9'd2}) begin
      n_fail++;
      $display("FAIL to_after: got b=%0b t=%0b cnt=%0d, want b=0 t=0 cnt=2", busy, tmo, wcnt);
    end
    n_checks++;
    if (seen_fin !== 0) begin
      n_fail++;
      $display("FAIL to_no_finish: got %0d finish cycles, want 0", seen_fin);
    end
  endtask

  task automatic test_enable_gating();
    start = 1; step(); start = 0;
    valid = 1;
    for (int i = 1; i <= 4; i++) begin
      en = 0; step();
      n_checks++;
      if ({busy, finish, wcnt} !== {2'b10, 9'(i - 1)}) begin
        n_fail++;
        $display("FAIL en_hold%0d: got b=%0b f=%0b cnt=%0d, want b=1 f=0 cnt=%0d", i, busy, finish, wcnt, i - 1);
      end
      en = 1; step();
    end
    valid = 0;
    n_checks++;
    if ({busy, finish, wcnt} !== {2'b01, 9'd4}) begin
      n_fail++;
      $display("FAIL en_finish: got b=%0b f=%0b cnt=%0d, want b=0 f=1 cnt=4", busy, finish, wcnt);
    end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (finish !== 1'b1) begin
        n_fail++;
        $display("FAIL en_stretch%0d: got f=%0b, want f=1", i, finish);
      end
    end
    en = 1; step();
    n_checks++;
    if ({busy, finish} !== 2'b00) begin
      n_fail++;
      $display("FAIL en_release: got b=%0b f=%0b, want b=0 f=0", busy, finish);
    end
  endtask

  task automatic test_back_to_back();
    start = 1; step(); start = 0;
    valid = 1; step(); step(); step(); step(); valid = 0;
    n_checks++;
    if ({finish, wcnt} !== {1'b1, 9'd4}) begin
      n_fail++;
      $display("FAIL b2b_first: got f=%0b cnt=%0d, want f=1 cnt=4", finish, wcnt);
    end
    start = 1; step(); start = 0;
    n_checks++;
    if ({busy, finish, wcnt} !== {2'b10, 9'd0}) begin
      n_fail++;
      $display("FAIL b2b_restart: got b=%0b f=%0b cnt=%0d, want b=1 f=0 cnt=0", busy, finish, wcnt);
    end
    valid = 1; step(); step(); step(); step(); valid = 0;
    n_checks++;
    if ({busy, finish, wcnt} !== {2'b01, 9'd4}) begin
      n_fail++;
      $display("FAIL b2b_second: got b=%0b f=%0b cnt=%0d, want b=0 f=1 cnt=4", busy, finish, wcnt);
    end
    step();
    n_checks++;
    if ({busy, finish} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_idle: got b=%0b f=%0b, want 0 0", busy, finish);
    end
  endtask

  task automatic test_mid_abort();
    int bad = 0;
    start = 1; step(); start = 0;
    valid = 1; step(); step();
    clr = 1; step(); clr = 0; valid = 0;
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b000, 9'd0}) begin
      n_fail++;
      $display("FAIL clr_mid: got b=%0b f=%0b t=%0b cnt=%0d, want all 0", busy, finish, tmo, wcnt);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy || finish || tmo) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL clr_quiet: got %0d active cycles, want 0", bad);
    end
    start = 1; step(); start = 0;
    valid = 1; step(); step(); step(); valid = 0;
    n_checks++;
    if ({busy, wcnt} !== {1'b1, 9'd3}) begin
      n_fail++;
      $display("FAIL rst_setup: got b=%0b cnt=%0d, want b=1 cnt=3", busy, wcnt);
    end
    #2 rst_n = 0; #1;
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b000, 9'd0}) begin
      n_fail++;
      $display("FAIL rst_async: got b=%0b f=%0b t=%0b cnt=%0d, want all 0", busy, finish, tmo, wcnt);
    end
    step(); rst_n = 1; bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy || finish || tmo || (wcnt != 0)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_quiet: got %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_boundaries();
    start = 1; step(); start = 0;
    valid = 1; step(); step(); step(); valid = 0;
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if ({busy, tmo, wcnt} !== {2'b10, 9'd3}) begin
      n_fail++;
      $display("FAIL race_pre: got b=%0b t=%0b cnt=%0d, want b=1 t=0 cnt=3", busy, tmo, wcnt);
    end
    valid = 1; step(); valid = 0;
    n_checks++;
    if ({busy, finish, tmo, wcnt} !== {3'b010, 9'd4}) begin
      n_fail++;
      $display("FAIL race_done: got b=%0b f=%0b t=%0b cnt=%0d, want b=0 f=1 t=0 cnt=4", busy, finish, tmo, wcnt);
    end
    step();
    n_checks++;
    if ({busy, finish, tmo} !== 3'b000) begin
      n_fail++;
      $display("FAIL race_after: got b=%0b f=%0b t=%0b, want 0 0 0", busy, finish, tmo);
    end
    start = 1; step(); start = 0;
    n_checks++;
    if ({busy1, finish1, wcnt1} !== {2'b10, 9'd0}) begin
      n_fail++;
      $display("FAIL len1_start: got b=%0b f=%0b cnt=%0d, want b=1 f=0 cnt=0", busy1, finish1, wcnt1);
    end
    valid = 1; step(); valid = 0;
    n_checks++;
    if ({busy1, finish1, tmo1, wcnt1} !== {3'b010, 9'd1}) begin
      n_fail++;
      $display("FAIL len1_finish: got b=%0b f=%0b t=%0b cnt=%0d, want b=0 f=1 t=0 cnt=1", busy1, finish1, tmo1, wcnt1);
    end
    step();
    n_checks++;
    if ({busy1, finish1, wcnt1} !== {2'b00, 9'd1}) begin
      n_fail++;
      $display("FAIL len1_after: got b=%0b f=%0b cnt=%0d, want b=0 f=0 cnt=1", busy1, finish1, wcnt1);
    end
    clr = 1; step(); clr = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_enable_gating();
    test_back_to_back();
    test_mid_abort();
    test_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_comm_frame_done_gen
